// File: rtl/serial_mag_compare_if.sv
// ============================================================================
// Module      : serial_mag_compare_if
// Description : Request/result bundle for the serial magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_mag_compare_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             a_gt_b;

  modport master (
    output start, a, b,
    input  busy, done, a_lt_b, a_eq_b, a_gt_b
  );

  modport slave (
    input  start, a, b,
    output busy, done, a_lt_b, a_eq_b, a_gt_b
  );
endinterface

`default_nettype wire

// File: rtl/serial_mag_compare.sv
// ============================================================================
// Module      : serial_mag_compare
// Description : Unsigned WIDTH-bit magnitude compare, one 4-bit slice per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mag_compare #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  serial_mag_compare_if.slave   bus
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] a_slice [NSLICE];
  logic [3:0] b_slice [NSLICE];
  logic [3:0] cur_a;
  logic [3:0] cur_b;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    assign a_slice[i] = a_q[4*i +: 4];
    assign b_slice[i] = b_q[4*i +: 4];
  end

  assign cur_a = a_slice[idx_q];
  assign cur_b = b_slice[idx_q];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // An unequal slice overrides everything below it; equal slices keep the cascade.
        if (cur_a > cur_b) begin
          lt_d = 1'b0;
          eq_d = 1'b0;
          gt_d = 1'b1;
        end else if (cur_a < cur_b) begin
          lt_d = 1'b1;
          eq_d = 1'b0;
          gt_d = 1'b0;
        end
        idx_d = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NSLICE - 1)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.a_lt_b = lt_q;
  assign bus.a_eq_b = eq_q;
  assign bus.a_gt_b = gt_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_mag_compare.sv
// ============================================================================
// Module      : tb_serial_mag_compare
// Description : Directed and random checks of serial_mag_compare (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_mag_compare;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_mag_compare_if #(.WIDTH(WIDTH)) bus ();

  serial_mag_compare #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {lt, eq, gt}
  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {x < y, x == y, x > y};
  endfunction

  function automatic logic [2:0] result();
    return {bus.a_lt_b, bus.a_eq_b, bus.a_gt_b};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // mode 0: quiet inputs; 1: start held high with A=0,B=9 during RUN; 2: random a/b during RUN.
  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input int mode);
    int         lat;
    int         busy_cnt;
    bit         seen;
    logic [2:0] e;
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    exp_q.push_back(ref_cmp(x, y));
    seen     = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    e        = 3'b000;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1'b1;
      bus.start = (mode == 1) && !seen;
      if (mode == 1) begin
        bus.a = '0;
        bus.b = 16'd9;
      end else if (mode == 2) begin
        bus.a = WIDTH'($urandom);
        bus.b = WIDTH'($urandom);
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, lat, NSLICE + 1);
      check({tag, "_busy_cycles"}, busy_cnt, NSLICE + 1);
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, "_result"}, 32'(result()), 32'(e));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
    check({tag, "_hold"}, 32'(result()), 32'(e));
  endtask

  initial begin
    bit         extra_done;
    logic [WIDTH-1:0] rx, ry;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(result()), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_cmp("eq_1234", 16'h1234, 16'h1234, 0);
    run_cmp("msb_override", 16'h8000, 16'h7FFF, 0);
    run_cmp("lt_small", 16'h0001, 16'h0002, 0);
    run_cmp("lsb_decides", 16'h1200, 16'h1201, 0);
    run_cmp("gt_lsb", 16'h1201, 16'h1200, 0);
    run_cmp("max_vs_zero", 16'hFFFF, 16'h0000, 0);
    run_cmp("zero_vs_max", 16'h0000, 16'hFFFF, 0);

    // A second start during RUN must be ignored and produce no extra done.
    run_cmp("start_ignored", 16'd5, 16'd3, 1);
    extra_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra_done = 1'b1;
    end
    check("start_not_queued", 32'(extra_done), 32'd0);

    // Reset in the second RUN cycle abandons the compare.
    bus.start = 1'b1;
    bus.a     = 16'h00FF;
    bus.b     = 16'h0F00;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_busy", 32'(bus.busy), 32'd0);
    check("midrun_rst_done", 32'(bus.done), 32'd0);
    check("midrun_rst_result", 32'(result()), 32'd0);
    extra_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) extra_done = 1'b1;
    end
    check("midrun_rst_no_done", 32'(extra_done), 32'd0);

    run_cmp("isolation_a", 16'hA5C3, 16'hA5C4, 2);
    run_cmp("isolation_b", 16'h7000, 16'h6FFF, 2);

    for (int i = 0; i < 200; i++) begin
      rx = WIDTH'($urandom);
      ry = (i % 8 == 0) ? rx : WIDTH'($urandom);
      if (i % 8 == 4) ry = {rx[WIDTH-1:4], 4'(ry)};
      run_cmp("random", rx, ry, 0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
